// File: rtl/fir_pkg.sv
// Shared width derivation, saturation limits and rounding constant for the
// parametrised transposed-form FIR.
package fir_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    // Accumulator is wide enough that summing NTAPS full-width products never wraps.
    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + clog2(ntaps);
    endfunction

    function automatic int addr_width(input int ntaps);
        return clog2(ntaps);
    endfunction

    function automatic logic signed [63:0] sat_max(input int ow);
        return (64'sd1 <<< (ow - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int ow);
        return -(64'sd1 <<< (ow - 1));
    endfunction

    // Half an output LSB, so the following arithmetic shift rounds half up.
    function automatic logic signed [63:0] round_const(input int shift);
        return (shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/fir_tap.sv
// One transposed-form tap: double-buffered coefficient, product register and
// accumulator register chained towards tap 0.
module fir_tap
    import fir_pkg::*;
#(
    parameter int DW = 18,
    parameter int CW = 18,
    parameter int AW = 40
) (
    input  logic                 i_clk,
    input  logic                 i_clr,
    input  logic signed [DW-1:0] i_din,
    input  logic                 i_we,
    input  logic signed [CW-1:0] i_coef_data,
    input  logic                 i_swap,
    input  logic                 i_pv,
    input  logic signed [AW-1:0] i_acc_in,
    output logic signed [AW-1:0] o_acc_out
);

    localparam int PW = DW + CW;

    logic signed [CW-1:0] r_shadow;
    logic signed [CW-1:0] r_active;
    logic signed [PW-1:0] r_prod;
    logic signed [AW-1:0] r_acc;

    logic signed [PW-1:0] w_din_ext;
    logic signed [PW-1:0] w_coef_ext;
    logic signed [AW-1:0] w_prod_ext;

    assign w_din_ext  = {{CW{i_din[DW-1]}}, i_din};
    assign w_coef_ext = {{DW{r_active[CW-1]}}, r_active};
    assign w_prod_ext = {{(AW-PW){r_prod[PW-1]}}, r_prod};

    // Swap reads the shadow before a same-edge write updates it.
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_shadow <= '0;
            r_active <= '0;
            r_prod   <= '0;
            r_acc    <= '0;
        end else begin
            if (i_swap) begin
                r_active <= r_shadow;
            end
            if (i_we) begin
                r_shadow <= i_coef_data;
            end
            r_prod <= w_din_ext * w_coef_ext;
            if (i_pv) begin
                r_acc <= w_prod_ext + i_acc_in;
            end
        end
    end

    assign o_acc_out = r_acc;

endmodule

// File: rtl/fir_ntap.sv
// Parametrised transposed-form FIR: NTAPS chained taps, run-time coefficient
// bank swap, rounded and saturated output with a one-cycle valid pulse.
module fir_ntap
    import fir_pkg::*;
#(
    parameter  int NTAPS  = 16,
    parameter  int DW     = 18,
    parameter  int CW     = 18,
    parameter  int OW     = 16,
    parameter  int SHIFT  = 17,
    localparam int AW     = acc_width(DW, CW, NTAPS),
    localparam int ADDR_W = addr_width(NTAPS)
) (
    input  logic                     i_clk,
    input  logic                     i_clr,
    input  logic                     i_ce,
    input  logic signed [DW-1:0]     i_din,
    input  logic                     i_coef_we,
    input  logic        [ADDR_W-1:0] i_coef_addr,
    input  logic signed [CW-1:0]     i_coef_data,
    input  logic                     i_coef_swap,
    output logic signed [OW-1:0]     res,
    output logic                     o_valid,
    output logic                     o_sat
);

    // Two guard bits keep the rounding add and limit compares free of wrap.
    localparam int RW = ((AW > OW) ? AW : OW) + 2;

    localparam logic signed [63:0] RC64  = round_const(SHIFT);
    localparam logic signed [63:0] MAX64 = sat_max(OW);
    localparam logic signed [63:0] MIN64 = sat_min(OW);

    localparam logic signed [RW-1:0] ROUND_C = RC64[RW-1:0];
    localparam logic signed [RW-1:0] SAT_MAX = MAX64[RW-1:0];
    localparam logic signed [RW-1:0] SAT_MIN = MIN64[RW-1:0];

    logic signed [AW-1:0] w_acc [NTAPS+1];
    logic [NTAPS-1:0]     w_we;

    logic r_pv;
    logic r_acc_v;
    logic r_valid;
    logic r_sat;
    logic signed [OW-1:0] r_res;

    logic signed [RW-1:0] w_sum;
    logic signed [RW-1:0] w_shr;
    logic signed [OW-1:0] w_res_next;
    logic                 w_sat_next;

    assign w_acc[NTAPS] = '0;

    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
        assign w_we[gi] = i_coef_we && (i_coef_addr == ADDR_W'(gi));

        fir_tap #(
            .DW (DW),
            .CW (CW),
            .AW (AW)
        ) u_tap (
            .i_clk       (i_clk),
            .i_clr       (i_clr),
            .i_din       (i_din),
            .i_we        (w_we[gi]),
            .i_coef_data (i_coef_data),
            .i_swap      (i_coef_swap),
            .i_pv        (r_pv),
            .i_acc_in    (w_acc[gi+1]),
            .o_acc_out   (w_acc[gi])
        );
    end

    assign w_sum = {{(RW-AW){w_acc[0][AW-1]}}, w_acc[0]} + ROUND_C;
    assign w_shr = w_sum >>> SHIFT;

    always_comb begin
        w_res_next = w_shr[OW-1:0];
        w_sat_next = 1'b0;
        if (w_shr > SAT_MAX) begin
            w_res_next = SAT_MAX[OW-1:0];
            w_sat_next = 1'b1;
        end else if (w_shr < SAT_MIN) begin
            w_res_next = SAT_MIN[OW-1:0];
            w_sat_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_pv    <= 1'b0;
            r_acc_v <= 1'b0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
            r_res   <= '0;
        end else begin
            r_pv    <= i_ce;
            r_acc_v <= r_pv;
            r_valid <= r_acc_v;
            if (r_acc_v) begin
                r_res <= w_res_next;
                r_sat <= w_sat_next;
            end
        end
    end

    assign res     = r_res;
    assign o_valid = r_valid;
    assign o_sat   = r_sat;

endmodule

// File: tb/tb_fir_ntap.sv
// Scoreboard bench for fir_ntap: three instances (small NTAPS=4, defaults,
// NTAPS=5 for out-of-range addressing), directed vectors, queue-based monitors.
module tb_fir_ntap;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr;

    logic                ce_a, we_a, swap_a, v_a, sat_a;
    logic signed [17:0]  din_a, cd_a;
    logic        [1:0]   addr_a;
    logic signed [39:0]  res_a;

    logic                ce_b, we_b, swap_b, v_b, sat_b;
    logic signed [17:0]  din_b, cd_b;
    logic        [3:0]   addr_b;
    logic signed [15:0]  res_b;

    logic                ce_c, we_c, swap_c, v_c, sat_c;
    logic signed [17:0]  din_c, cd_c;
    logic        [2:0]   addr_c;
    logic signed [39:0]  res_c;

    fir_ntap #(.NTAPS(4), .DW(18), .CW(18), .OW(40), .SHIFT(0)) u_dut_a (
        .i_clk(clk), .i_clr(clr), .i_ce(ce_a), .i_din(din_a),
        .i_coef_we(we_a), .i_coef_addr(addr_a), .i_coef_data(cd_a),
        .i_coef_swap(swap_a), .res(res_a), .o_valid(v_a), .o_sat(sat_a)
    );

    fir_ntap u_dut_b (
        .i_clk(clk), .i_clr(clr), .i_ce(ce_b), .i_din(din_b),
        .i_coef_we(we_b), .i_coef_addr(addr_b), .i_coef_data(cd_b),
        .i_coef_swap(swap_b), .res(res_b), .o_valid(v_b), .o_sat(sat_b)
    );

    fir_ntap #(.NTAPS(5), .DW(18), .CW(18), .OW(40), .SHIFT(0)) u_dut_c (
        .i_clk(clk), .i_clr(clr), .i_ce(ce_c), .i_din(din_c),
        .i_coef_we(we_c), .i_coef_addr(addr_c), .i_coef_data(cd_c),
        .i_coef_swap(swap_c), .res(res_c), .o_valid(v_c), .o_sat(sat_c)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint r;
        bit     s;
        int     due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Drive one cycle on one instance (others idle); optionally queue the expected output.
    task automatic step(input int inst, input bit ce, input longint din, input bit we,
                        input int addr, input longint cd, input bit sw,
                        input bit ev, input longint er, input bit es);
        exp_t e;
        ce_a = 0; we_a = 0; swap_a = 0; din_a = '0; addr_a = '0; cd_a = '0;
        ce_b = 0; we_b = 0; swap_b = 0; din_b = '0; addr_b = '0; cd_b = '0;
        ce_c = 0; we_c = 0; swap_c = 0; din_c = '0; addr_c = '0; cd_c = '0;
        case (inst)
            0: begin ce_a = ce; din_a = 18'(din); we_a = we; addr_a = 2'(addr); cd_a = 18'(cd); swap_a = sw; end
            1: begin ce_b = ce; din_b = 18'(din); we_b = we; addr_b = 4'(addr); cd_b = 18'(cd); swap_b = sw; end
            default: begin ce_c = ce; din_c = 18'(din); we_c = we; addr_c = 3'(addr); cd_c = 18'(cd); swap_c = sw; end
        endcase
        e.r = er;
        e.s = es;
        e.due = cyc + 3;
        if (ev) begin
            case (inst)
                0: qa.push_back(e);
                1: qb.push_back(e);
                default: qc.push_back(e);
            endcase
        end
        @(negedge clk);
    endtask

    task automatic wr(input int inst, input int addr, input longint d);
        step(inst, 0, 0, 1, addr, d, 0, 0, 0, 0);
    endtask

    task automatic swp(input int inst);
        step(inst, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic smp(input int inst, input longint x, input longint er, input bit es);
        step(inst, 1, x, 0, 0, 0, 0, 1, er, es);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (v_a) begin
            if (qa.size() == 0) chk("A unexpected valid", 1, 0);
            else begin
                e = qa.pop_front();
                $display("A out res=%0d sat=%0d exp=%0d/%0d", res_a, sat_a, e.r, e.s);
                chk("A res", res_a, e.r);
                chk("A sat", sat_a, e.s);
                chk("A latency", cyc, e.due);
            end
        end else if (qa.size() > 0 && qa[0].due < cyc) begin
            chk("A missing valid", 0, 1);
            void'(qa.pop_front());
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (v_b) begin
            if (qb.size() == 0) chk("B unexpected valid", 1, 0);
            else begin
                e = qb.pop_front();
                $display("B out res=%0d sat=%0d exp=%0d/%0d", res_b, sat_b, e.r, e.s);
                chk("B res", res_b, e.r);
                chk("B sat", sat_b, e.s);
                chk("B latency", cyc, e.due);
            end
        end else if (qb.size() > 0 && qb[0].due < cyc) begin
            chk("B missing valid", 0, 1);
            void'(qb.pop_front());
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (v_c) begin
            if (qc.size() == 0) chk("C unexpected valid", 1, 0);
            else begin
                e = qc.pop_front();
                $display("C out res=%0d sat=%0d exp=%0d/%0d", res_c, sat_c, e.r, e.s);
                chk("C res", res_c, e.r);
                chk("C sat", sat_c, e.s);
                chk("C latency", cyc, e.due);
            end
        end else if (qc.size() > 0 && qc[0].due < cyc) begin
            chk("C missing valid", 0, 1);
            void'(qc.pop_front());
        end
    end

    initial begin
        clr = 1'b1;
        idle(3);
        chk("reset res_a", res_a, 0);
        chk("reset valid_a", v_a, 0);
        chk("reset sat_a", sat_a, 0);
        chk("reset res_b", res_b, 0);
        chk("reset valid_b", v_b, 0);
        chk("reset sat_b", sat_b, 0);
        clr = 1'b0;

        // Impulse on the 4-tap instance
        wr(0, 0, 3); wr(0, 1, -5); wr(0, 2, 7); wr(0, 3, 11); swp(0);
        smp(0, 1, 3, 0); smp(0, 0, -5, 0); smp(0, 0, 7, 0); smp(0, 0, 11, 0); smp(0, 0, 0, 0);
        idle(4);

        // Gapped input: idle cycles insert no zeros into history
        smp(0, 1, 3, 0); idle(2);
        smp(0, 0, -5, 0); idle(2);
        smp(0, 0, 7, 0); idle(2);
        smp(0, 0, 11, 0); idle(4);

        // Swap boundary: shadow rewrites during streaming have no effect until swap
        wr(0, 0, 1); wr(0, 1, 0); wr(0, 2, 0); wr(0, 3, 0); swp(0);
        step(0, 1, 5, 1, 0, 2, 0, 1, 5, 0);
        step(0, 1, 5, 1, 1, 0, 0, 1, 5, 0);
        step(0, 1, 5, 1, 2, 0, 0, 1, 5, 0);
        step(0, 1, 5, 1, 3, 0, 0, 1, 5, 0);
        step(0, 1, 5, 0, 0, 0, 1, 1, 5, 0);
        smp(0, 5, 10, 0); smp(0, 5, 10, 0);
        idle(4);

        // Rounding on the default instance
        wr(1, 0, 1); swp(1);
        smp(1, 65536, 1, 0); smp(1, 65535, 0, 0); smp(1, -65537, -1, 0);
        idle(4);

        // Saturation: full-scale positive, drain, full-scale negative
        for (int i = 0; i < 16; i++) wr(1, i, 131071);
        swp(1);
        for (int i = 0; i < 16; i++) smp(1, 131071, 32767, 1);
        for (int i = 0; i < 16; i++) smp(1, 0, (i < 15) ? 32767 : 0, (i < 15));
        for (int i = 0; i < 16; i++) smp(1, -131072, -32768, 1);
        idle(4);

        // Out-of-range coefficient addresses are ignored
        wr(2, 0, 1); wr(2, 5, 99); wr(2, 7, 99); swp(2);
        smp(2, 1, 1, 0);
        for (int i = 0; i < 4; i++) smp(2, 0, 0, 0);
        idle(4);

        // Reset in the middle of a stream
        for (int i = 0; i < 5; i++) smp(0, 3, 6, 0);
        #2;
        ce_a = 1'b0;
        clr  = 1'b1;
        #1;
        chk("midreset res_a", res_a, 0);
        chk("midreset valid_a", v_a, 0);
        chk("midreset sat_a", sat_a, 0);
        qa.delete();
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        smp(0, 7, 0, 0);
        idle(3);
        wr(0, 0, 3); wr(0, 1, -5); wr(0, 2, 7); wr(0, 3, 11); swp(0);
        smp(0, 1, 3, 0); smp(0, 0, -5, 0); smp(0, 0, 7, 0); smp(0, 0, 11, 0);
        idle(6);

        chk("queues drained", qa.size() + qb.size() + qc.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
